// File: rtl/pulse_shaper_tx_pkg.sv
// Shared definitions for the pulse shaper: state encoding and default phase lengths.
// The default phase lengths match the input debouncer's target count.
package pulse_shaper_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        HIGH     = 2'b01,
        LOW_HOLD = 2'b10
    } state_e;

    localparam int unsigned DEF_HIGH_CYCLES = 5;
    localparam int unsigned DEF_LOW_CYCLES  = 5;
    localparam int unsigned DEF_CNT_W       = 4;
    localparam int unsigned DEF_PEND_W      = 3;

    // The spare encoding 2'b11 is treated as IDLE everywhere.
    function automatic logic is_active(input state_e s);
        return (s == HIGH) || (s == LOW_HOLD);
    endfunction

endpackage

// File: rtl/pulse_shaper_tx_phase_timer.sv
// Phase counter for the pulse shaper.
// It counts up while enabled, clears synchronously, and flags the last cycle of a phase.
module phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = en_i && (count_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/pulse_shaper_tx.sv
// Turns single-cycle requests into pulses with a guaranteed high width and low gap.
// Requests that arrive during a pulse are queued in a saturating pending counter.
module pulse_shaper_tx
    import pulse_shaper_tx_pkg::*;
#(
    parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
    parameter int unsigned LOW_CYCLES  = DEF_LOW_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned PEND_W      = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_req,
    input  logic              clr_overflow,
    output logic              signal_out,
    output logic              busy,
    output logic              ready,
    output logic              pulse_done,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    state_e            state_q;
    logic              signal_out_q;
    logic [PEND_W-1:0] pending_q;
    logic              overflow_q;

    logic              timer_done;
    logic [CNT_W-1:0]  timer_limit;
    logic              in_idle;
    logic              pend_zero;
    logic              pend_full;
    logic              last_low;
    logic              pend_inc;
    logic              pend_dec;
    logic              pend_drop;

    assign in_idle     = !is_active(state_q);
    assign pend_zero   = (pending_q == '0);
    assign pend_full   = (pending_q == '1);
    assign last_low    = (state_q == LOW_HOLD) && timer_done;
    assign timer_limit = (state_q == HIGH) ? CNT_W'(HIGH_CYCLES) : CNT_W'(LOW_CYCLES);

    // In IDLE a request is consumed directly by the pulse it starts, so it never queues.
    assign pend_inc  = pulse_req && !in_idle;
    assign pend_dec  = !pend_zero && ((in_idle && !pulse_req) || last_low);
    assign pend_drop = pend_inc && !pend_dec && pend_full;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clr_i   (timer_done || in_idle),
        .en_i    (!in_idle),
        .limit_i (timer_limit),
        .done_o  (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            signal_out_q <= 1'b0;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                HIGH: begin
                    if (timer_done) begin
                        state_q      <= LOW_HOLD;
                        signal_out_q <= 1'b0;
                    end
                end
                LOW_HOLD: begin
                    if (timer_done) begin
                        if (!pend_zero) begin
                            state_q      <= HIGH;
                            signal_out_q <= 1'b1;
                        end else begin
                            state_q      <= IDLE;
                            signal_out_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (pulse_req || !pend_zero) begin
                        state_q      <= HIGH;
                        signal_out_q <= 1'b1;
                    end else begin
                        state_q      <= IDLE;
                        signal_out_q <= 1'b0;
                    end
                end
            endcase

            if (pend_inc && !pend_dec && !pend_full) begin
                pending_q <= pending_q + PEND_W'(1);
            end else if (pend_dec && !pend_inc) begin
                pending_q <= pending_q - PEND_W'(1);
            end

            if (pend_drop) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign signal_out = signal_out_q;
    assign busy       = !in_idle;
    assign ready      = in_idle && pend_zero;
    assign pulse_done = (state_q == HIGH) && timer_done;
    assign pending    = pending_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_shaper_tx.sv
// Directed bench for pulse_shaper_tx with default parameters.
// Outputs are traced per cycle and compared against hand-derived cycle masks.
module tb_pulse_shaper_tx;

    logic       clk;
    logic       rst_n;
    logic       pulse_req;
    logic       clr_overflow;
    logic       signal_out;
    logic       busy;
    logic       ready;
    logic       pulse_done;
    logic [2:0] pending;
    logic       overflow;

    int n_cmp;
    int n_bad;
    int cyc;

    logic [63:0] sig_tr, busy_tr, done_tr, ready_tr, ovf_tr;
    logic [2:0]  pend_tr [0:63];

    pulse_shaper_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_req    (pulse_req),
        .clr_overflow (clr_overflow),
        .signal_out   (signal_out),
        .busy         (busy),
        .ready        (ready),
        .pulse_done   (pulse_done),
        .pending      (pending),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic record();
        if (cyc < 64) begin
            sig_tr[cyc]   = signal_out;
            busy_tr[cyc]  = busy;
            done_tr[cyc]  = pulse_done;
            ready_tr[cyc] = ready;
            ovf_tr[cyc]   = overflow;
            pend_tr[cyc]  = pending;
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        pulse_req    = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc      = 0;
        sig_tr   = '0;
        busy_tr  = '0;
        done_tr  = '0;
        ready_tr = '0;
        ovf_tr   = '0;
        for (int i = 0; i < 64; i++) pend_tr[i] = '0;
        record();
    endtask

    // Inputs applied in cycle cyc are sampled at the edge that ends it.
    task automatic run_to(input int last, input logic [63:0] reqs, input logic [63:0] clrs);
        while (cyc < last) begin
            pulse_req    = reqs[cyc];
            clr_overflow = clrs[cyc];
            @(posedge clk);
            #1;
            pulse_req    = 1'b0;
            clr_overflow = 1'b0;
            cyc++;
            record();
        end
    endtask

    logic [63:0] reqs;

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // 1: reset state, then async reset in the middle of a pulse
        do_reset();
        chk_val("rst_sig",   64'(signal_out), 64'd0);
        chk_val("rst_busy",  64'(busy),       64'd0);
        chk_val("rst_ready", 64'(ready),      64'd1);
        chk_val("rst_pend",  64'(pending),    64'd0);
        chk_val("rst_ovf",   64'(overflow),   64'd0);
        reqs = '0; reqs[10] = 1'b1; reqs[12] = 1'b1;
        run_to(13, reqs, '0);
        chk_val("mid_pre_sig",  64'(signal_out), 64'd1);
        chk_val("mid_pre_pend", 64'(pending),    64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_val("mid_rst_sig",   64'(signal_out), 64'd0);
        chk_val("mid_rst_pend",  64'(pending),    64'd0);
        chk_val("mid_rst_busy",  64'(busy),       64'd0);
        chk_val("mid_rst_ready", 64'(ready),      64'd1);

        // 2: single request
        do_reset();
        reqs = '0; reqs[10] = 1'b1;
        run_to(40, reqs, '0);
        chk_val("t2_sig",   sig_tr,   span(11, 15));
        chk_val("t2_done",  done_tr,  span(15, 15));
        chk_val("t2_busy",  busy_tr,  span(11, 20));
        chk_val("t2_ready", ready_tr, span(0, 10) | span(21, 40));

        // 3: second request queued during the first pulse
        do_reset();
        reqs = '0; reqs[10] = 1'b1; reqs[12] = 1'b1;
        run_to(40, reqs, '0);
        chk_val("t3_sig",    sig_tr, span(11, 15) | span(21, 25));
        chk_val("t3_pend12", 64'(pend_tr[12]), 64'd0);
        chk_val("t3_pend13", 64'(pend_tr[13]), 64'd1);
        chk_val("t3_pend20", 64'(pend_tr[20]), 64'd1);
        chk_val("t3_pend21", 64'(pend_tr[21]), 64'd0);
        chk_val("t3_busy",   busy_tr,  span(11, 30));
        chk_val("t3_ready31", 64'(ready_tr[31]), 64'd1);

        // 4: burst of 10 requests saturates the queue; overflow cleared at cycle 40
        do_reset();
        reqs = span(10, 19);
        run_to(50, reqs, span(40, 40));
        chk_val("t4_pend12", 64'(pend_tr[12]), 64'd1);
        chk_val("t4_pend17", 64'(pend_tr[17]), 64'd6);
        chk_val("t4_pend18", 64'(pend_tr[18]), 64'd7);
        chk_val("t4_pend20", 64'(pend_tr[20]), 64'd7);
        chk_val("t4_pend21", 64'(pend_tr[21]), 64'd6);
        chk_val("t4_pend41", 64'(pend_tr[41]), 64'd4);
        chk_val("t4_ovf",    ovf_tr, span(19, 40));
        chk_val("t4_sig",    sig_tr, span(11, 15) | span(21, 25) | span(31, 35) | span(41, 45));
        chk_val("t4_done",   done_tr, span(15, 15) | span(25, 25) | span(35, 35) | span(45, 45));

        // 5: request in the final low cycle with an empty queue
        do_reset();
        reqs = '0; reqs[10] = 1'b1; reqs[20] = 1'b1;
        run_to(40, reqs, '0);
        chk_val("t5_pend21",  64'(pend_tr[21]),  64'd1);
        chk_val("t5_busy21",  64'(busy_tr[21]),  64'd0);
        chk_val("t5_ready21", 64'(ready_tr[21]), 64'd0);
        chk_val("t5_pend22",  64'(pend_tr[22]),  64'd0);
        chk_val("t5_sig",     sig_tr, span(11, 15) | span(22, 26));

        // 6a: request in IDLE while one is already pending
        do_reset();
        reqs = '0; reqs[10] = 1'b1; reqs[20] = 1'b1; reqs[21] = 1'b1;
        run_to(45, reqs, '0);
        chk_val("t6a_pend22", 64'(pend_tr[22]), 64'd1);
        chk_val("t6a_pend32", 64'(pend_tr[32]), 64'd0);
        chk_val("t6a_sig",    sig_tr, span(11, 15) | span(22, 26) | span(32, 36));

        // 6b: request in the last low cycle while pending > 0
        do_reset();
        reqs = '0; reqs[10] = 1'b1; reqs[12] = 1'b1; reqs[20] = 1'b1;
        run_to(45, reqs, '0);
        chk_val("t6b_pend21", 64'(pend_tr[21]), 64'd1);
        chk_val("t6b_pend31", 64'(pend_tr[31]), 64'd0);
        chk_val("t6b_sig",    sig_tr, span(11, 15) | span(21, 25) | span(31, 35));

        // 6c: drop coincident with clear keeps overflow set; a later plain clear works
        do_reset();
        reqs = span(10, 19);
        run_to(30, reqs, span(19, 19) | span(21, 21));
        chk_val("t6c_ovf", ovf_tr & span(0, 30), span(19, 21));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
